// File: rtl/muldiv.sv
// ---------------------------------------------------------------------------
// muldiv: sequential 8x8 multiplier and 16/8 restoring divider.
//
// An operation is accepted from IDLE on a rising edge with i_start high. It
// then runs one iteration per cycle for 8 cycles in RUN (o_busy high). After
// that, one DONE cycle pulses o_done with the result on o_r/o_flags.
// Divide-by-zero and quotient overflow skip RUN and finish in the first
// cycle. The result stays held until the next accepted operation completes.
//
// Ports:
//   i_clk       - clock, all state changes on the rising edge
//   i_reset     - synchronous active-high reset, priority over i_start
//   i_start     - operation request, sampled only in IDLE
//   i_op        - 0 = MLT (i_a[7:0] * i_b), 1 = DIV (i_a / i_b)
//   i_a[15:0]   - MLT multiplicand in [7:0]; DIV 16-bit dividend
//   i_b[7:0]    - multiplier or divisor
//   o_busy      - high while an accepted operation iterates
//   o_done      - one-cycle completion pulse; o_r/o_flags valid then
//   o_r[15:0]   - result; DIV packs {remainder, quotient}
//   o_flags[3:0]- [0] Z, [1] C, [2] V, [3] S
//   o_div_zero  - one-cycle pulse with o_done for DIV by zero
//
// Configuration macro:
//   MULDIV_DIV_EN - includes the division datapath. Without it, a DIV request
//                   completes at once with o_r = 16'hFACE and clear flags.
// ---------------------------------------------------------------------------
module muldiv (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_r,
  output logic [3:0]  o_flags,
  output logic        o_div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_count;

  // Shift-add multiplier: the multiplicand moves left and the multiplier
  // moves right, so bit 0 of r_mplier always selects the current partial product.
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] w_accNext;

  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MULDIV_DIV_EN
  // Restoring divider: r_quot starts as the low dividend byte. Its MSB feeds
  // the partial remainder each step, and quotient bits enter at the LSB.
  // The remainder is always below the divisor, so the 8-bit subtract result
  // is exact.
  logic        r_op;
  logic [7:0]  r_rem;
  logic [7:0]  r_quot;
  logic [7:0]  r_divisor;
  logic [8:0]  w_trial;
  logic        w_fits;
  logic [7:0]  w_remNext;
  logic [7:0]  w_quotNext;

  assign w_trial    = {r_rem, r_quot[7]};
  assign w_fits     = (w_trial >= {1'b0, r_divisor});
  assign w_remNext  = w_fits ? (w_trial[7:0] - r_divisor) : w_trial[7:0];
  assign w_quotNext = {r_quot[6:0], w_fits};
`else
  // The dividend high byte only matters to the divider.
  logic        w_unused;
  assign w_unused = ^i_a[15:8];
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= 3'd0;
      r_acc      <= 16'h0000;
      r_mcand    <= 16'h0000;
      r_mplier   <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      o_r        <= 16'h0000;
      o_flags    <= 4'h0;
`ifdef MULDIV_DIV_EN
      r_op       <= 1'b0;
      r_rem      <= 8'h00;
      r_quot     <= 8'h00;
      r_divisor  <= 8'h00;
`endif
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count  <= 3'd0;
            r_acc    <= 16'h0000;
            r_mcand  <= {8'h00, i_a[7:0]};
            r_mplier <= i_b;
            if (i_op) begin
`ifdef MULDIV_DIV_EN
              r_op      <= 1'b1;
              r_rem     <= i_a[15:8];
              r_quot    <= i_a[7:0];
              r_divisor <= i_b;
              // A zero divisor always trips this too, because i_a[15:8] >= 0.
              // A high byte >= divisor means the quotient cannot fit in 8 bits.
              if (i_a[15:8] >= i_b) begin
                r_state    <= S_DONE;
                o_done     <= 1'b1;
                o_r        <= i_a;
                o_flags    <= 4'b0100;
                o_div_zero <= (i_b == 8'h00);
              end else begin
                r_state <= S_RUN;
                o_busy  <= 1'b1;
              end
`else
              r_state <= S_DONE;
              o_done  <= 1'b1;
              o_r     <= 16'hFACE;
              o_flags <= 4'h0;
`endif
            end else begin
`ifdef MULDIV_DIV_EN
              r_op    <= 1'b0;
`endif
              r_state <= S_RUN;
              o_busy  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          r_acc    <= w_accNext;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
`ifdef MULDIV_DIV_EN
          r_rem    <= w_remNext;
          r_quot   <= w_quotNext;
`endif
          // The eighth iteration publishes its combinational step result
          // directly, so the counter never has to wrap past 7.
          if (r_count == 3'd7) begin
            r_state <= S_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (r_op) begin
              o_r     <= {w_remNext, w_quotNext};
              o_flags <= {w_quotNext[7], 2'b00, (w_quotNext == 8'h00)};
            end else begin
              o_r     <= w_accNext;
              o_flags <= {w_accNext[15], 2'b00, (w_accNext == 16'h0000)};
            end
`else
            o_r     <= w_accNext;
            o_flags <= {w_accNext[15], 2'b00, (w_accNext == 16'h0000)};
`endif
          end else begin
            r_count <= r_count + 3'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// ---------------------------------------------------------------------------
// tb_muldiv: directed testbench for muldiv with hand-computed expectations.
// Cycle 1 is the cycle after the edge that accepts start. Outputs are sampled
// on the falling edge. DIV expectations follow the MULDIV_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] r;
  logic [3:0]  flags;
  logic        divZero;

  int numChecks   = 0;
  int numFailures = 0;

  muldiv dut (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_start    (start),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_r        (r),
    .o_flags    (flags),
    .o_div_zero (divZero)
  );

  always #5 clock = ~clock;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFailures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge in IDLE. Returns at the falling edge of cycle 1
  // with start dropped and the operands scrambled, to prove they were latched.
  task automatic applyStimulus(input logic opIn, input logic [15:0] aIn,
                               input logic [7:0] bIn);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    op    = ~opIn;
    a     = ~aIn;
    b     = ~bIn;
  endtask

  // Runs one operation and checks the done cycle, the result, the busy
  // profile and the cycle after done. Returns at the falling edge of the
  // first IDLE cycle after done. A nonzero injectCycle re-pulses start there.
  task automatic runAndCheck(input string tag, input logic opIn,
                             input logic [15:0] aIn, input logic [7:0] bIn,
                             input int expCycle, input logic [15:0] expR,
                             input logic [3:0] expFlags, input logic expDz,
                             input int injectCycle);
    int          doneCycle = 0;
    logic [31:0] busyMask  = 32'h0;
    logic [31:0] expBusy   = 32'h0;
    logic [15:0] gotR      = 16'h0;
    logic [3:0]  gotFlags  = 4'h0;
    logic        gotDz     = 1'b0;
    applyStimulus(opIn, aIn, bIn);
    for (int c = 1; c <= 20; c++) begin
      if (c == injectCycle) begin
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h00FF;
        b     = 8'hFF;
      end
      if (c == injectCycle + 1) start = 1'b0;
      busyMask[c] = busy;
      if (done) begin
        doneCycle = c;
        gotR      = r;
        gotFlags  = flags;
        gotDz     = divZero;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    @(negedge clock);
    busyMask[doneCycle + 1] = busy;
    for (int k = 1; k < expCycle; k++) expBusy[k] = 1'b1;
    checkOutput({tag, "/doneCycle"}, doneCycle, expCycle);
    checkOutput({tag, "/R"}, gotR, expR);
    checkOutput({tag, "/flags"}, gotFlags, expFlags);
    checkOutput({tag, "/divZero"}, gotDz, expDz);
    checkOutput({tag, "/busyProfile"}, busyMask, expBusy);
    checkOutput({tag, "/doneAfter"}, done, 1'b0);
    checkOutput({tag, "/divZeroAfter"}, divZero, 1'b0);
    checkOutput({tag, "/holdR"}, r, expR);
    checkOutput({tag, "/holdFlags"}, flags, expFlags);
  endtask

  initial begin
    int doneSeen;
    // Reset with start held high: the request must be ignored.
    reset = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h0003;
    b     = 8'h03;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checkOutput("reset/busy", busy, 1'b0);
    checkOutput("reset/done", done, 1'b0);
    checkOutput("reset/R", r, 16'h0000);
    checkOutput("reset/flags", flags, 4'h0);
    checkOutput("reset/divZero", divZero, 1'b0);

    // Multiplication patterns.
    runAndCheck("mlt10x10", 1'b0, 16'h0010, 8'h10, 9, 16'h0100, 4'h0, 1'b0, 0);
    runAndCheck("mltFFxFF", 1'b0, 16'h00FF, 8'hFF, 9, 16'hFE01, 4'b1000, 1'b0, 0);
    runAndCheck("mltZero", 1'b0, 16'h5500, 8'h37, 9, 16'h0000, 4'b0001, 1'b0, 0);
    runAndCheck("mlt0Cx0D", 1'b0, 16'h120C, 8'h0D, 9, 16'h009C, 4'h0, 1'b0, 0);

    // Division patterns.
`ifdef MULDIV_DIV_EN
    runAndCheck("div1234", 1'b1, 16'h1234, 8'h56, 9, 16'h1036, 4'h0, 1'b0, 0);
    runAndCheck("divOvf", 1'b1, 16'h5600, 8'h56, 1, 16'h5600, 4'b0100, 1'b0, 0);
    runAndCheck("divByZero", 1'b1, 16'h0050, 8'h00, 1, 16'h0050, 4'b0100, 1'b1, 0);
    runAndCheck("divFFby1", 1'b1, 16'h00FF, 8'h01, 9, 16'h00FF, 4'b1000, 1'b0, 0);
    runAndCheck("divSmall", 1'b1, 16'h0005, 8'h07, 9, 16'h0500, 4'b0001, 1'b0, 0);
`else
    runAndCheck("div1234", 1'b1, 16'h1234, 8'h56, 1, 16'hFACE, 4'h0, 1'b0, 0);
    runAndCheck("divOvf", 1'b1, 16'h5600, 8'h56, 1, 16'hFACE, 4'h0, 1'b0, 0);
    runAndCheck("divByZero", 1'b1, 16'h0050, 8'h00, 1, 16'hFACE, 4'h0, 1'b0, 0);
`endif

    // Start re-pulsed mid-operation is ignored.
    runAndCheck("mltRestart", 1'b0, 16'h0007, 8'h09, 9, 16'h003F, 4'h0, 1'b0, 4);

    // Reset during cycle 4 aborts the operation with no done pulse.
`ifdef MULDIV_DIV_EN
    applyStimulus(1'b1, 16'h1234, 8'h56);
`else
    applyStimulus(1'b0, 16'h0011, 8'h22);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort/busy", busy, 1'b0);
    checkOutput("abort/R", r, 16'h0000);
    checkOutput("abort/flags", flags, 4'h0);
    doneSeen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) doneSeen++;
      @(negedge clock);
    end
    checkOutput("abort/noDone", doneSeen, 0);
    runAndCheck("mltAfterAbort", 1'b0, 16'h0003, 8'h05, 9, 16'h000F, 4'h0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             numChecks, numFailures);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 SHALL have port op, input, 1 bit: 0 = MLT (R = A[7:0] * B), 1 = DIV (A / B).
REQ-005 SHALL have port A, input, 16 bits: MLT multiplicand in A[7:0]; DIV 16-bit dividend.
REQ-006 SHALL have port B, input, 8 bits: multiplier or divisor.
REQ-007 SHALL have port busy, output, 1 bit: high while an accepted operation is running.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse; R and flags are valid in that cycle.
REQ-009 SHALL have port R, output, 16 bits: result; DIV packs {remainder, quotient}.
REQ-010 SHALL have port flags, output, 4 bits: [0] Z, [1] C, [2] V, [3] S.
REQ-011 SHALL have port div_zero, output, 1 bit: one-cycle pulse coincident with done for DIV with B = 0.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE, latch op/A/B on that edge and ignore later changes to those inputs.
REQ-014 SHALL ignore start while in RUN or DONE; no queueing.
REQ-015 SHALL, for a normal accept at edge 0, hold busy high in cycles 1-8 (RUN, one iteration per cycle).
REQ-016 SHALL pulse done in cycle 9 (DONE), then return to IDLE; busy is low in DONE.
REQ-017 MLT SHALL use 8-step shift-add: R = A[7:0] * B (16-bit); Z = (R == 0); S = R[15]; C = 0; V = 0.
REQ-018 DIV SHALL use 8-step restoring division: R[7:0] = quotient, R[15:8] = remainder.
REQ-019 DIV flags: Z = (quotient == 0); S = quotient[7]; C = 0; V = 0.
REQ-020 SHALL treat DIV with B == 0 as divide-by-zero: go IDLE->DONE, done in cycle 1, R = A, flags = V only (4'b0100), div_zero pulses.
REQ-021 SHALL treat DIV with A[15:8] >= B, B != 0, as overflow (quotient > 255): go IDLE->DONE, done in cycle 1, R = A, flags = 4'b0100, div_zero low.
REQ-022 SHALL hold R and flags stable from done until the next accepted start completes.
REQ-023 SHALL allow start to be accepted in the cycle immediately after done (IDLE).
REQ-024 SHALL count iterations with a 3-bit counter, with no wrap beyond 8 steps.

Reset
REQ-025 SHALL, on reset, set state = IDLE, busy = 0, done = 0, div_zero = 0, R = 16'h0000, flags = 4'h0 and clear the iteration counter.
REQ-026 SHALL give reset priority over start and abort any operation in progress, with no done pulse.
REQ-027 SHALL ignore a start asserted together with reset.

Configuration
REQ-028 SHALL use macro MULDIV_DIV_EN to include the division datapath.
REQ-029 SHALL, with MULDIV_DIV_EN defined, implement DIV per REQ-018 to REQ-021.
REQ-030 SHALL, without MULDIV_DIV_EN, go IDLE->DONE for op = 1 with done in cycle 1, R = 16'hFACE, flags = 4'h0, div_zero = 0; MLT is unaffected.

Verification
REQ-031 SHALL pass: MLT, A=16'h0010, B=8'h10 -> done at cycle 9, R=16'h0100, flags=4'h0; busy high cycles 1-8.
REQ-032 SHALL pass: MLT, A=16'h00FF, B=8'hFF -> R=16'hFE01, flags=4'b1000; then MLT with A[7:0]=0 -> R=0, flags=4'b0001.
REQ-033 SHALL pass: DIV, A=16'h1234, B=8'h56 -> done at cycle 9, R=16'h1036, flags=4'h0.
REQ-034 SHALL pass: DIV, A=16'h5600, B=8'h56 -> done at cycle 1, R=16'h5600, flags=4'b0100, div_zero=0; DIV with B=0 -> same timing, div_zero=1.
REQ-035 SHALL pass: start pulsed again at cycle 4 of an MLT -> ignored, single done at cycle 9 with the first result.
REQ-036 SHALL pass: reset at cycle 4 of a DIV -> next cycle busy=0, R=0, flags=0, no done; a new MLT completes normally.
